data_check: RTL and testbench

DATA_CHECK -- requirements
Module: data_check

---
 rtl/data_check.sv | 188 ++++++++++++++++++
 tb/tb_data_check.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_check.sv
// data_check: AXI-Stream sink that checks a 32-lane, 16-bit counting pattern.
// Every lane of a beat must carry the same value, consecutive beats must
// count up by one, and TLAST must close every PACKET_BEATS-beat packet.
// The block keeps beat/packet/error counters and sticky error flags, and can
// optionally throttle TREADY to exercise upstream backpressure.
module data_check #(
   parameter int          PACKET_BEATS  = 4,
   parameter logic [15:0] FIRST_VALUE   = 16'h0001,
   parameter bit          SYNC_ON_FIRST = 1'b0,
   parameter int          THROTTLE_N    = 0
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [511:0] AXIS_TDATA,
   input  logic         AXIS_TVALID,
   input  logic         AXIS_TLAST,
   output logic         AXIS_TREADY,
   input  logic         clear,
   output logic [31:0]  beat_count,
   output logic [31:0]  packet_count,
   output logic [15:0]  error_count,
   output logic         err_lane,
   output logic         err_seq,
   output logic         err_last
);

   localparam int                IDX_W    = $clog2(PACKET_BEATS + 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PACKET_BEATS);

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      RUN        = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              ready_en_q, ready_en_d;
   logic [15:0]       exp_data_q, exp_data_d;
   logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
   logic [31:0]       beat_count_q, beat_count_d;
   logic [31:0]       packet_count_q, packet_count_d;
   logic [15:0]       error_count_q, error_count_d;
   logic              err_lane_q, err_lane_d;
   logic              err_seq_q, err_seq_d;
   logic              err_last_q, err_last_d;

   logic              tready_raw;
   logic              accept;
   logic [15:0]       lane0;
   logic [31:1]       lane_mis;
   logic              lane_bad;
   logic              seq_bad;
   logic              last_bad;
   logic              any_bad;

   // ------------------------------------------------------------------
   // Ready generation. ready_en_q holds TREADY low through reset and
   // until the first clock edge afterwards; the optional throttle counter
   // then removes one ready cycle in every THROTTLE_N.
   // ------------------------------------------------------------------
   generate
      if (THROTTLE_N >= 1) begin : g_throttle
         localparam int               THR_W   = (THROTTLE_N > 1) ? $clog2(THROTTLE_N) : 1;
         localparam logic [THR_W-1:0] THR_MAX = THR_W'(THROTTLE_N - 1);
         logic [THR_W-1:0] thr_q, thr_d;

         // Free-running 0..THROTTLE_N-1 counter, independent of traffic and clear
         always_comb begin
            thr_d = (thr_q == THR_MAX) ? '0 : thr_q + THR_W'(1);
         end

         // Throttle counter register
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               thr_q <= '0;
            end else begin
               thr_q <= thr_d;
            end
         end

         assign tready_raw = (thr_q != THR_MAX);
      end else begin : g_no_throttle
         assign tready_raw = 1'b1;
      end
   endgenerate

   assign AXIS_TREADY = ready_en_q & tready_raw;
   assign accept      = AXIS_TVALID & AXIS_TREADY;

   // ------------------------------------------------------------------
   // Beat checks
   // ------------------------------------------------------------------
   assign lane0 = AXIS_TDATA[15:0];

   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_lane
         assign lane_mis[gi] = (AXIS_TDATA[16*gi +: 16] != lane0);
      end
   endgenerate

   assign lane_bad = |lane_mis;
   // The very first beat seeds the sequence when SYNC_ON_FIRST is set
   assign seq_bad  = (lane0 != exp_data_q) && !(SYNC_ON_FIRST && (state_q == WAIT_FIRST));
   assign last_bad = AXIS_TLAST != (beat_idx_q == LAST_IDX);
   assign any_bad  = lane_bad | seq_bad | last_bad;

   // Next-state logic: leave WAIT_FIRST on the first accepted beat, then stay in RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_FIRST: if (accept) state_d = RUN;
         RUN:        state_d = RUN;
         default:    state_d = WAIT_FIRST;
      endcase
   end

   // Sequence and framing tracking: both resync to what was actually received
   always_comb begin
      ready_en_d = 1'b1;
      exp_data_d = exp_data_q;
      beat_idx_d = beat_idx_q;
      if (accept) begin
         exp_data_d = lane0 + 16'd1;
         if (AXIS_TLAST || (beat_idx_q == LAST_IDX)) begin
            beat_idx_d = IDX_ONE;
         end else begin
            beat_idx_d = beat_idx_q + IDX_W'(1);
         end
      end
   end

   // Counters and sticky flags; clear drops history but keeps the current beat
   always_comb begin
      beat_count_d   = clear ? 32'd0 : beat_count_q;
      packet_count_d = clear ? 32'd0 : packet_count_q;
      error_count_d  = clear ? 16'd0 : error_count_q;
      err_lane_d     = clear ? 1'b0  : err_lane_q;
      err_seq_d      = clear ? 1'b0  : err_seq_q;
      err_last_d     = clear ? 1'b0  : err_last_q;
      if (accept) begin
         beat_count_d = beat_count_d + 32'd1;
         if (AXIS_TLAST) begin
            packet_count_d = packet_count_d + 32'd1;
         end
         if (any_bad && (error_count_d != 16'hFFFF)) begin
            error_count_d = error_count_d + 16'd1;
         end
         err_lane_d = err_lane_d | lane_bad;
         err_seq_d  = err_seq_d  | seq_bad;
         err_last_d = err_last_d | last_bad;
      end
   end

   // State, tracking and statistics registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= WAIT_FIRST;
         ready_en_q     <= 1'b0;
         exp_data_q     <= FIRST_VALUE;
         beat_idx_q     <= IDX_ONE;
         beat_count_q   <= 32'd0;
         packet_count_q <= 32'd0;
         error_count_q  <= 16'd0;
         err_lane_q     <= 1'b0;
         err_seq_q      <= 1'b0;
         err_last_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         ready_en_q     <= ready_en_d;
         exp_data_q     <= exp_data_d;
         beat_idx_q     <= beat_idx_d;
         beat_count_q   <= beat_count_d;
         packet_count_q <= packet_count_d;
         error_count_q  <= error_count_d;
         err_lane_q     <= err_lane_d;
         err_seq_q      <= err_seq_d;
         err_last_q     <= err_last_d;
      end
   end

   assign beat_count   = beat_count_q;
   assign packet_count = packet_count_q;
   assign error_count  = error_count_q;
   assign err_lane     = err_lane_q;
   assign err_seq      = err_seq_q;
   assign err_last     = err_last_q;

endmodule

// File: tb/tb_data_check.sv
// tb_data_check: directed, table-driven bench for data_check.
// u_dut0 uses defaults, u_dut1 syncs on its first beat, u_dut2 throttles 1-in-4.
module tb_data_check;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [511:0]  tdata = '0;
   logic          tlast = 1'b0;
   logic          clear = 1'b0;
   logic [2:0]    tv = 3'b000;

   logic          tr [3];
   logic [31:0]   bc [3];
   logic [31:0]   pc [3];
   logic [15:0]   ec [3];
   logic          fl_lane [3];
   logic          fl_seq [3];
   logic          fl_last [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   data_check u_dut0 (
      .clk(clk), .resetn(resetn), .AXIS_TDATA(tdata), .AXIS_TVALID(tv[0]),
      .AXIS_TLAST(tlast), .AXIS_TREADY(tr[0]), .clear(clear),
      .beat_count(bc[0]), .packet_count(pc[0]), .error_count(ec[0]),
      .err_lane(fl_lane[0]), .err_seq(fl_seq[0]), .err_last(fl_last[0])
   );

   data_check #(.SYNC_ON_FIRST(1'b1)) u_dut1 (
      .clk(clk), .resetn(resetn), .AXIS_TDATA(tdata), .AXIS_TVALID(tv[1]),
      .AXIS_TLAST(tlast), .AXIS_TREADY(tr[1]), .clear(clear),
      .beat_count(bc[1]), .packet_count(pc[1]), .error_count(ec[1]),
      .err_lane(fl_lane[1]), .err_seq(fl_seq[1]), .err_last(fl_last[1])
   );

   data_check #(.THROTTLE_N(4)) u_dut2 (
      .clk(clk), .resetn(resetn), .AXIS_TDATA(tdata), .AXIS_TVALID(tv[2]),
      .AXIS_TLAST(tlast), .AXIS_TREADY(tr[2]), .clear(clear),
      .beat_count(bc[2]), .packet_count(pc[2]), .error_count(ec[2]),
      .err_lane(fl_lane[2]), .err_seq(fl_seq[2]), .err_last(fl_last[2])
   );

   typedef struct {
      logic        clr;
      logic        vld;
      logic [15:0] v;
      int          lane;
      logic [15:0] lv;
      logic        last;
      logic [31:0] eb;
      logic [31:0] ep;
      logic [15:0] ee;
      logic [2:0]  ef;   // {err_lane, err_seq, err_last}
   } vec_t;

   localparam int NVEC = 30;
   vec_t tbl [NVEC];

   int          thr_v;
   int          thr_k;

   function automatic vec_t row(input bit c, input bit vl, input int v, input int ln,
                                input int lv, input bit lst, input int eb, input int ep,
                                input int ee, input bit [2:0] ef);
      vec_t r;
      r.clr  = c;
      r.vld  = vl;
      r.v    = 16'(v);
      r.lane = ln;
      r.lv   = 16'(lv);
      r.last = lst;
      r.eb   = 32'(eb);
      r.ep   = 32'(ep);
      r.ee   = 16'(ee);
      r.ef   = ef;
      return r;
   endfunction

   // All lanes = v, except lane 'lane' (when non-zero) = lv
   function automatic logic [511:0] mk(input logic [15:0] v, input int lane, input logic [15:0] lv);
      logic [511:0] d;
      for (int k = 0; k < 32; k++) d[16*k +: 16] = v;
      if (lane != 0) d[16*lane +: 16] = lv;
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int d, input logic [31:0] eb,
                          input logic [31:0] ep, input logic [15:0] ee, input logic [2:0] ef);
      chk({tag, " beat_count"},   bc[d], eb);
      chk({tag, " packet_count"}, pc[d], ep);
      chk({tag, " error_count"},  32'(ec[d]), 32'(ee));
      chk({tag, " flags"}, 32'({fl_lane[d], fl_seq[d], fl_last[d]}), 32'(ef));
   endtask

   task automatic thr_drive();
      tdata = mk(16'(thr_v), 0, 16'h0);
      tlast = ((thr_v % 4) == 0);
   endtask

   // Run n cycles on u_dut2 with TVALID held high; k counts edges since reset release
   task automatic thr_cycles(input int n);
      logic r;
      logic e;
      for (int i = 0; i < n; i++) begin
         e = (thr_k != 0) && ((thr_k % 4) != 3);
         chk($sformatf("throttle tready k=%0d", thr_k), 32'(tr[2]), 32'(e));
         r = tr[2];
         @(posedge clk); #1;
         $display("[TB] throttle k=%0d tready=%0b value=%0d", thr_k, r, thr_v);
         if (r) begin
            thr_v++;
            thr_drive();
         end
         thr_k++;
      end
   endtask

   initial begin
      logic [15:0] sv [4];

      // v: lane0 value; lane/lv: odd lane override; expected counts after the edge
      tbl[0]  = row(0, 1, 1,  0, 0, 0, 1, 0, 0, 3'b000);
      tbl[1]  = row(0, 1, 2,  0, 0, 0, 2, 0, 0, 3'b000);
      tbl[2]  = row(0, 1, 3,  0, 0, 0, 3, 0, 0, 3'b000);
      tbl[3]  = row(0, 1, 4,  0, 0, 1, 4, 1, 0, 3'b000);
      tbl[4]  = row(0, 1, 5,  0, 0, 0, 5, 1, 0, 3'b000);
      tbl[5]  = row(0, 1, 6,  0, 0, 0, 6, 1, 0, 3'b000);
      tbl[6]  = row(0, 1, 7,  0, 0, 0, 7, 1, 0, 3'b000);
      tbl[7]  = row(0, 1, 8,  0, 0, 1, 8, 2, 0, 3'b000);
      tbl[8]  = row(0, 0, 99, 3, 7, 1, 8, 2, 0, 3'b000);   // idle cycle, junk inputs
      tbl[9]  = row(1, 0, 0,  0, 0, 0, 0, 0, 0, 3'b000);   // clear
      tbl[10] = row(0, 1, 9,  0, 0, 0, 1, 0, 0, 3'b000);
      tbl[11] = row(0, 1, 10, 0, 0, 0, 2, 0, 0, 3'b000);
      tbl[12] = row(0, 1, 11, 17, 12, 0, 3, 0, 1, 3'b100); // lane 17 off by one
      tbl[13] = row(0, 1, 12, 0, 0, 1, 4, 1, 1, 3'b100);
      tbl[14] = row(1, 1, 13, 5, 0, 0, 1, 0, 1, 3'b100);   // clear + bad beat together
      tbl[15] = row(1, 0, 0,  0, 0, 0, 0, 0, 0, 3'b000);
      tbl[16] = row(0, 1, 14, 0, 0, 0, 1, 0, 0, 3'b000);
      tbl[17] = row(0, 1, 16, 0, 0, 0, 2, 0, 1, 3'b010);   // skipped 15
      tbl[18] = row(0, 1, 17, 0, 0, 1, 3, 1, 1, 3'b010);
      tbl[19] = row(0, 1, 18, 0, 0, 0, 4, 1, 1, 3'b010);
      tbl[20] = row(1, 0, 0,  0, 0, 0, 0, 0, 0, 3'b000);
      tbl[21] = row(0, 1, 19, 0, 0, 0, 1, 0, 0, 3'b000);
      tbl[22] = row(0, 1, 20, 0, 0, 1, 2, 1, 1, 3'b001);   // TLAST one beat early
      tbl[23] = row(0, 1, 21, 0, 0, 0, 3, 1, 1, 3'b001);
      tbl[24] = row(0, 1, 22, 0, 0, 0, 4, 1, 1, 3'b001);
      tbl[25] = row(0, 1, 23, 0, 0, 0, 5, 1, 1, 3'b001);
      tbl[26] = row(0, 1, 24, 0, 0, 1, 6, 2, 1, 3'b001);
      tbl[27] = row(0, 1, 30, 31, 0, 1, 7, 3, 2, 3'b111); // three faults, one count
      tbl[28] = row(0, 1, 16'hFFFF, 0, 0, 0, 8, 3, 3, 3'b111);
      tbl[29] = row(0, 1, 0,  0, 0, 0, 9, 3, 3, 3'b111);   // 0xFFFF -> 0x0000 is in sequence

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk_all($sformatf("reset dut%0d", d), d, 32'd0, 32'd0, 16'd0, 3'b000);
         chk($sformatf("reset dut%0d tready", d), 32'(tr[d]), 32'd0);
      end
      resetn = 1'b1;
      #1;
      chk("tready before first edge", 32'(tr[0]), 32'd0);
      @(posedge clk); #1;
      chk("tready after first edge", 32'(tr[0]), 32'd1);

      // Table on the default instance, one row per clock
      for (int i = 0; i < NVEC; i++) begin
         clear = tbl[i].clr;
         tv[0] = tbl[i].vld;
         tdata = mk(tbl[i].v, tbl[i].lane, tbl[i].lv);
         tlast = tbl[i].last;
         @(posedge clk); #1;
         clear = 1'b0;
         tv[0] = 1'b0;
         $display("[TB] row %0d clr=%0b vld=%0b v=0x%04h last=%0b -> beats=%0d pkts=%0d errs=%0d",
                  i, tbl[i].clr, tbl[i].vld, tbl[i].v, tbl[i].last, bc[0], pc[0], ec[0]);
         chk_all($sformatf("row%0d", i), 0, tbl[i].eb, tbl[i].ep, tbl[i].ee, tbl[i].ef);
      end

      // Sync-on-first instance: sequence wrapping through 0xFFFF
      sv[0] = 16'hFFFE; sv[1] = 16'hFFFF; sv[2] = 16'h0000; sv[3] = 16'h0001;
      for (int j = 0; j < 4; j++) begin
         tv[1] = 1'b1;
         tdata = mk(sv[j], 0, 16'h0);
         tlast = (j == 3);
         @(posedge clk); #1;
         tv[1] = 1'b0;
         $display("[TB] sync beat %0d v=0x%04h -> beats=%0d errs=%0d", j, sv[j], bc[1], ec[1]);
      end
      chk_all("sync", 1, 32'd4, 32'd1, 16'd0, 3'b000);

      // Throttled instance: two beats, reset mid-packet, then a clean restart
      resetn = 1'b0;
      thr_v = 1;
      thr_k = 0;
      thr_drive();
      tv[2] = 1'b1;
      #2;
      resetn = 1'b1;
      thr_cycles(3);
      chk("throttle pre-reset beat_count", bc[2], 32'd2);
      resetn = 1'b0;
      #1;
      chk_all("throttle in reset", 2, 32'd0, 32'd0, 16'd0, 3'b000);
      chk("throttle in reset tready", 32'(tr[2]), 32'd0);
      thr_v = 1;
      thr_k = 0;
      thr_drive();
      #1;
      resetn = 1'b1;
      thr_cycles(12);
      chk_all("throttle restart", 2, 32'd8, 32'd2, 16'd0, 3'b000);
      tv[2] = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
